// File: rtl/score_sequencer.sv
// score_sequencer: records (gate-vector, duration) entries into a small score
// buffer and plays them back at a fixed tick rate, one gate per wave generator.
//
//   state | meaning
//   IDLE  | gates low; accepts records and start
//   LOAD  | one cycle; the addressed entry is in the read register
//   HOLD  | gates driven from the entry; ticks count down its duration
module score_sequencer #(
  parameter int NOTES    = 8,
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1562500,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             rec_valid,
  input  logic [NOTES-1:0] rec_gates,
  input  logic [DUR_W-1:0] rec_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [NOTES-1:0] note_gates,
  output logic [AW-1:0]    step,
  output logic             playing,
  output logic             done,
  output logic [AW:0]      length,
  output logic             rec_full
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = NOTES + DUR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [NOTES-1:0] gates_q, gates_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             done_q, done_d;
  logic [AW:0]      len_q, len_d;
  logic             wr_en;

  logic [EW-1:0]    mem [0:DEPTH-1];
  logic [EW-1:0]    rd_q;
  logic [NOTES-1:0] rd_gates;
  logic [DUR_W-1:0] rd_dur;
  logic             tick;
  logic             last_entry;

  assign rd_gates   = rd_q[EW-1:DUR_W];
  assign rd_dur     = rd_q[DUR_W-1:0];
  assign tick       = (pre_q == PW'(TICK_DIV - 1));
  assign last_entry = (({1'b0, step_q} + (AW+1)'(1)) >= len_q);

  // Score storage: write at the record pointer, registered read addressed by
  // the next step so the entry is ready by the time LOAD is reached.
  always_ff @(posedge clock) begin
    if (wr_en) mem[len_q[AW-1:0]] <= {rec_gates, rec_dur};
    rd_q <= mem[step_d];
  end

  // Control state and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      gates_q <= '0;
      rem_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gates_q <= gates_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic; clear and stop override whatever the FSM would do.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gates_d = gates_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    len_d   = len_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      step_d  = '0;
      gates_d = '0;
      pre_d   = '0;
      len_d   = '0;
    end else if (stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      gates_d = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gates_d = '0;
          step_d  = '0;
          if (start) begin
            if (len_q != '0) state_d = S_LOAD;
          end else if (rec_valid && (len_q != (AW+1)'(DEPTH))) begin
            wr_en = 1'b1;
            len_d = len_q + (AW+1)'(1);
          end
        end
        S_LOAD: begin
          state_d = S_HOLD;
          gates_d = rd_gates;
          rem_d   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
          pre_d   = '0;
        end
        S_HOLD: begin
          if (tick) begin
            pre_d = '0;
            if (rem_q == DUR_W'(1)) begin
              if (!last_entry) begin
                step_d  = step_q + AW'(1);
                state_d = S_LOAD;
              end else if (loop) begin
                step_d  = '0;
                state_d = S_LOAD;
              end else begin
                step_d  = '0;
                gates_d = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              rem_d = rem_q - DUR_W'(1);
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign note_gates = gates_q;
  assign step       = step_q;
  assign playing    = (state_q != S_IDLE);
  assign done       = done_q;
  assign length     = len_q;
  assign rec_full   = (len_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_score_sequencer.sv
// Testbench for score_sequencer: expected playback is expanded from the
// recorded score into a cycle-by-cycle timeline and compared against the DUT.
module tb_score_sequencer;

  localparam int NOTES = 8;
  localparam int DEPTH = 4;
  localparam int DUR_W = 4;
  localparam int TD    = 4;

  logic             clock = 1'b0;
  logic             reset, clear, rec_valid, start, stop, loop;
  logic [NOTES-1:0] rec_gates;
  logic [DUR_W-1:0] rec_dur;
  logic [NOTES-1:0] note_gates;
  logic [1:0]       step;
  logic             playing, done;
  logic [2:0]       length;
  logic             rec_full;

  int chk_n = 0;
  int err_n = 0;

  // score model and expected timeline {gates, playing, step, done}
  logic [7:0]  m_g[$];
  int          m_d[$];
  logic [11:0] exp_q[$];

  score_sequencer #(.NOTES(NOTES), .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .clear(clear), .rec_valid(rec_valid),
    .rec_gates(rec_gates), .rec_dur(rec_dur), .start(start), .stop(stop),
    .loop(loop), .note_gates(note_gates), .step(step), .playing(playing),
    .done(done), .length(length), .rec_full(rec_full)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end (got timeout, required completion)");
    $fatal(1);
  end

  task automatic clk();
    @(posedge clock);
    #1;
  endtask

  task automatic do_rec(input logic [7:0] g, input logic [3:0] d);
    rec_valid = 1'b1;
    rec_gates = g;
    rec_dur   = d;
    clk();
    rec_valid = 1'b0;
    if (m_g.size() < DEPTH) begin
      m_g.push_back(g);
      m_d.push_back(int'(d));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    clk();
    clear = 1'b0;
    m_g.delete();
    m_d.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk();
    start = 1'b0;
  endtask

  // Timeline of one or more passes starting at the first LOAD cycle.
  task automatic build_trace(input int passes, input bit with_done);
    logic [7:0] prev;
    int d;
    prev = 8'h00;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < m_g.size(); i++) begin
        exp_q.push_back({prev, 1'b1, 2'(i), 1'b0});
        d = (m_d[i] == 0) ? 1 : m_d[i];
        for (int c = 0; c < d * TD; c++) exp_q.push_back({m_g[i], 1'b1, 2'(i), 1'b0});
        prev = m_g[i];
      end
    end
    if (with_done) begin
      exp_q.push_back({8'h00, 1'b0, 2'b00, 1'b1});
      exp_q.push_back({8'h00, 1'b0, 2'b00, 1'b0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; rec_valid = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    rec_gates = '0; rec_dur = '0;
    clk(); clk();
    reset = 1'b0;
    chk_n++; if (note_gates !== 8'h00) begin err_n++; $display("FAIL reset_gates: got %h required 00", note_gates); end
    chk_n++; if (step !== 2'd0) begin err_n++; $display("FAIL reset_step: got %0d required 0", step); end
    chk_n++; if (playing !== 1'b0) begin err_n++; $display("FAIL reset_playing: got %b required 0", playing); end
    chk_n++; if (done !== 1'b0) begin err_n++; $display("FAIL reset_done: got %b required 0", done); end
    chk_n++; if (length !== 3'd0) begin err_n++; $display("FAIL reset_length: got %0d required 0", length); end
    chk_n++; if (rec_full !== 1'b0) begin err_n++; $display("FAIL reset_full: got %b required 0", rec_full); end
  endtask

  task automatic test_record_play();
    logic [11:0] obs;
    do_clear();
    do_rec(8'h01, 4'd2);
    do_rec(8'h80, 4'd1);
    chk_n++; if (length !== 3'd2) begin err_n++; $display("FAIL rp_length: got %0d required 2", length); end
    pulse_start();
    build_trace(1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL rp_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
    chk_n++; if (length !== 3'd2) begin err_n++; $display("FAIL rp_length_after: got %0d required 2", length); end
  endtask

  task automatic test_loop();
    logic [11:0] obs;
    do_clear();
    do_rec(8'h01, 4'd2);
    do_rec(8'h80, 4'd1);
    loop = 1'b1;
    pulse_start();
    build_trace(4, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 3 * 14 + 5) loop = 1'b0;
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL loop_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
  endtask

  task automatic test_full_zero();
    logic [11:0] obs;
    do_clear();
    do_rec(8'h03, 4'd0);
    do_rec(8'h0C, 4'd1);
    do_rec(8'h30, 4'd2);
    do_rec(8'hC0, 4'd0);
    do_rec(8'hFF, 4'd3);
    chk_n++; if (length !== 3'd4) begin err_n++; $display("FAIL full_length: got %0d required 4", length); end
    chk_n++; if (rec_full !== 1'b1) begin err_n++; $display("FAIL full_flag: got %b required 1", rec_full); end
    pulse_start();
    build_trace(1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL full_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
  endtask

  task automatic test_random();
    logic [11:0] obs;
    int n;
    for (int it = 0; it < 20; it++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) do_rec(8'($urandom), 4'($urandom_range(0, 5)));
      chk_n++;
      if (length !== 3'(n)) begin err_n++; $display("FAIL rnd_length: got %0d required %0d", length, n); end
      pulse_start();
      build_trace(1, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = {note_gates, playing, step, done};
        chk_n++;
        if (obs !== exp_q[i]) begin err_n++; $display("FAIL rnd_trace[%0d.%0d]: got %h required %h", it, i, obs, exp_q[i]); end
        clk();
      end
    end
  endtask

  task automatic test_collisions();
    logic [11:0] obs;
    do_clear();
    pulse_start();
    chk_n++; if (playing !== 1'b0) begin err_n++; $display("FAIL empty_start_playing: got %b required 0", playing); end
    clk();
    chk_n++; if ({playing, done} !== 2'b00) begin err_n++; $display("FAIL empty_start_done: got %b required 00", {playing, done}); end
    do_rec(8'h01, 4'd2);
    do_rec(8'h80, 4'd1);
    start = 1'b1; stop = 1'b1;
    clk();
    start = 1'b0; stop = 1'b0;
    chk_n++; if (playing !== 1'b0) begin err_n++; $display("FAIL start_stop_playing: got %b required 0", playing); end
    clk();
    chk_n++; if ({playing, done} !== 2'b00) begin err_n++; $display("FAIL start_stop_idle: got %b required 00", {playing, done}); end
    pulse_start();
    build_trace(1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      rec_valid = (i == 3);
      rec_gates = 8'hAA;
      rec_dur   = 4'd1;
      start     = (i == 6);
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL busy_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
    rec_valid = 1'b0; start = 1'b0;
    chk_n++; if (length !== 3'd2) begin err_n++; $display("FAIL busy_length: got %0d required 2", length); end
    start = 1'b1; rec_valid = 1'b1; rec_gates = 8'h55; rec_dur = 4'd1;
    clk();
    start = 1'b0; rec_valid = 1'b0;
    build_trace(1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL start_rec_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
    chk_n++; if (length !== 3'd2) begin err_n++; $display("FAIL start_rec_length: got %0d required 2", length); end
  endtask

  task automatic test_abort();
    logic [11:0] obs;
    int hold_cycles;
    do_clear();
    do_rec(8'h01, 4'd2);
    do_rec(8'h80, 4'd1);
    pulse_start();
    build_trace(1, 1'b1);
    hold_cycles = 11 + $urandom_range(0, 2);
    for (int i = 0; i < hold_cycles; i++) begin
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL abort_pre[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
    stop = 1'b1;
    clk();
    stop = 1'b0;
    obs = {note_gates, playing, step, done};
    chk_n++; if (obs !== 12'h000) begin err_n++; $display("FAIL stop_outputs: got %h required 000", obs); end
    clk();
    chk_n++; if (done !== 1'b0) begin err_n++; $display("FAIL stop_no_done: got %b required 0", done); end
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = {note_gates, playing, step, done};
      chk_n++;
      if (obs !== exp_q[i]) begin err_n++; $display("FAIL replay_trace[%0d]: got %h required %h", i, obs, exp_q[i]); end
      clk();
    end
    pulse_start();
    clk(); clk(); clk();
    chk_n++; if (note_gates !== 8'h01) begin err_n++; $display("FAIL clear_pre_gates: got %h required 01", note_gates); end
    do_clear();
    chk_n++; if (length !== 3'd0) begin err_n++; $display("FAIL clear_length: got %0d required 0", length); end
    obs = {note_gates, playing, step, done};
    chk_n++; if (obs !== 12'h000) begin err_n++; $display("FAIL clear_outputs: got %h required 000", obs); end
    chk_n++; if (rec_full !== 1'b0) begin err_n++; $display("FAIL clear_full: got %b required 0", rec_full); end
    do_rec(8'h5A, 4'd3);
    pulse_start();
    clk(); clk(); clk(); clk();
    chk_n++; if (note_gates !== 8'h5A) begin err_n++; $display("FAIL reset_pre_gates: got %h required 5a", note_gates); end
    reset = 1'b1;
    clk();
    reset = 1'b0;
    m_g.delete(); m_d.delete();
    obs = {note_gates, playing, step, done};
    chk_n++; if (obs !== 12'h000) begin err_n++; $display("FAIL reset_mid_outputs: got %h required 000", obs); end
    chk_n++; if ({length, rec_full} !== 4'h0) begin err_n++; $display("FAIL reset_mid_length: got %h required 0", {length, rec_full}); end
  endtask

  initial begin
    test_reset();
    test_record_play();
    test_loop();
    test_full_zero();
    test_random();
    test_collisions();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
# score_sequencer

Parametrised note-gate sequencer for the audio path: it records a score of (gate-vector, duration) entries into an internal buffer, then plays them back at a fixed tick rate, driving one gate per wave generator. It replaces hard-coded per-song gate logic and fixed 10-bit record/play sequences with a configurable-width, configurable-depth block that supports loop mode. It sits between the switch/key inputs and the bank of wave generators. Its `note_gates` feed the generators' `play_note` inputs directly.

## Interface
- NOTES, 8, number of gate channels (width of gate vectors)
- DEPTH, 16, score entries stored; AW = clog2(DEPTH)
- DUR_W, 8, duration field width, in ticks
- TICK_DIV, 1562500, clocks per tick (1/32 s at 50 MHz); minimum 1
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- clear  in  1  pulse: empty the score and force idle
- rec_valid  in  1  append {rec_gates, rec_dur} at the write pointer
- rec_gates  in  NOTES  gate vector to record
- rec_dur  in  DUR_W  duration in ticks; 0 is treated as 1
- start  in  1  pulse: begin playback from entry 0
- stop  in  1  pulse: abort playback
- loop  in  1  level, sampled at end of each pass: 1 = restart at entry 0
- note_gates  out  NOTES  current gate vector
- step  out  AW  index of the entry currently loaded or held
- playing  out  1  high in LOAD or HOLD
- done  out  1  one-cycle pulse when a non-looping pass completes
- length  out  AW+1  number of stored entries, 0..DEPTH
- rec_full  out  1  length == DEPTH

## Operation
- Storage: DEPTH x (NOTES+DUR_W) array with synchronous read. Entry i is written by the i-th accepted rec_valid since the last clear/reset.
- States: IDLE, LOAD, HOLD.
- IDLE: note_gates = 0. On start with length > 0, go to LOAD with step = 0. On start with length == 0, ignore the request: no state change and no done.
- LOAD, one cycle: read the entry at step. Next state is HOLD. note_gates keeps its previous value during this cycle.
- HOLD: note_gates = stored gates, remaining = max(dur,1). A prescaler runs 0..TICK_DIV-1 and is cleared on HOLD entry. Each prescaler wrap decrements remaining. When the final tick expires:
  - If step < length-1: step++, go to LOAD.
  - Else if loop=1: step = 0, go to LOAD.
  - Else: go to IDLE, note_gates = 0, done = 1 for one cycle, step = 0.
- Recording: accepted only in IDLE and when length < DEPTH. It writes the entry and increments length. When ignored (playing or full), storage and length are unchanged.
- Priority, highest first: reset > clear > stop > start > rec_valid.
  - clear: length = 0, state IDLE, gates 0, step 0, no done.
  - stop: state IDLE, gates 0, step 0, no done. The score is kept.
  - start while playing: ignored.
  - start and rec_valid in the same IDLE cycle: start wins and the record is dropped.
- Arithmetic: remaining is a DUR_W counter; step wraps only through the loop path, never by overflow; length saturates at DEPTH.

## Timing
- Reset values: note_gates 0, step 0, playing 0, done 0, length 0, rec_full 0, state IDLE, prescaler 0.
- Array contents are not reset; they are unreachable while length = 0.
- start sampled at cycle t: playing = 1 at t+1 (LOAD); note_gates = entry 0 at t+2.
- Entry with duration d occupies d*TICK_DIV HOLD cycles plus 1 LOAD cycle before the next entry's gates appear.
- Pass of n entries, no loop: done pulses exactly sum(max(d_i,1))*TICK_DIV + n cycles after the first LOAD cycle. playing falls in the same cycle done is high.
- Loop restart costs exactly one LOAD cycle (no IDLE gap).
- length and rec_full update the cycle after an accepted rec_valid.
- clear and stop take effect on outputs the following cycle.

## Test plan
- Record and play, TICK_DIV=4: record {0x01,d=2}, {0x80,d=1}, pulse start. Required response:
  - gates 0x01 for 8 cycles, 1 LOAD cycle, then gates 0x80 for 4 cycles.
  - done pulses once, gates return to 0, length stays 2.
- Loop: same score with loop=1 for 3 passes. Required response:
  - gate pattern repeats with period 14 cycles and no done.
  - Drop loop mid-pass: done fires at the end of that pass.
- Full and zero-duration: with DEPTH=4, issue 5 rec_valid. Required response:
  - length = 4, rec_full = 1, the 5th record is dropped.
  - An entry with dur=0 holds for exactly 4 cycles.
- Control collisions:
  - start with length=0: no playing, no done.
  - start+stop in the same cycle: stays IDLE.
  - rec_valid during playback: length unchanged.
  - start during playback: step sequence unaffected.
- Abort and reset: stop in HOLD of entry 1 gives gates 0, step 0, no done, and start replays from entry 0. Then:
  - clear mid-HOLD gives length 0 and IDLE.
  - reset mid-HOLD gives all outputs at reset values the next cycle.
